microsequencer: RTL and testbench
=================================

# microsequencer

Next-state generator for the microprogrammed control unit. Each cycle it takes the 40-bit control word produced by the microstore for the current state, evaluates the next-state select and condition fields, and registers the 10-bit `next_state` that indexes the microstore on the following cycle. It also provides a microsubroutine return stack, a bounded memory-wait timeout, and sticky error reporting.

## Interface
- `NUM_STATES`, default 256: number of valid microstore states. Any target ≥ NUM_STATES is illegal.
- `STACK_DEPTH`, default 4: number of return-stack entries.
- `WAIT_LIMIT`, default 1023: maximum number of cycles spent held in one WAIT microinstruction.

Ports:
- `clk`, input, 1: the single clock. All state updates occur on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `cw`, input, 40: control word for the current state, driven by the microstore.
- `decode_state`, input, 10: start state from the instruction encoder for the current instruction register.
- `moc`, input, 1: memory operation complete.
- `cond`, input, 1: branch condition from the condition tester.
- `next_state`, output, 10: registered microstore address. It is also the current state held by this block.
- `stack_level`, output, 3: number of valid return-stack entries.
- `wait_cnt`, output, 10: stall cycles counted in the current WAIT microinstruction.
- `err`, output, 1: sticky error flag.
- `err_code`, output, 2: code of the first error. 00 = range, 01 = timeout, 10 = overflow, 11 = underflow.

## Operation
- Control word fields:
  - `sel = cw[39:37]`
  - `inv = cw[11]`
  - `csel = cw[10:8]`
  - `CR = {2'b0, cw[7:0]}`
- Condition `c = raw ^ inv`. `raw` is selected by `csel`:
  - 000: 0
  - 001: `moc`
  - 010: `cond`
  - 011: 1
  - 1xx: 0
- `inc = next_state + 1`, computed in 10 bits; it wraps at 1023.
- Next-state selection by `sel`:
  - 000 RESTART: state 0. An all-zero, unused microstore entry therefore restarts fetch.
  - 001 DECODE: `decode_state`.
  - 010 INC: `inc`.
  - 011 BRANCH: `c ? CR : inc`.
  - 100 WAIT: `c ? inc : next_state` (hold).
  - 101 BRDEC: `c ? CR : decode_state`.
  - 110 CALL: push `inc`, then go to `CR`.
    - If `stack_level == STACK_DEPTH`: no push, go to state 0, raise overflow.
  - 111 RETURN: pop the top entry and go to it.
    - If `stack_level == 0`: go to state 0, raise underflow.
- The range check is applied after selection. If the chosen target is ≥ NUM_STATES, go to state 0 and raise range. The stack push or pop still commits.
- Timeout:
  - In WAIT with `c == 0`: `wait_cnt` increments.
  - If `wait_cnt == WAIT_LIMIT-1` on such a cycle: go to state 0, clear `wait_cnt`, raise timeout.
  - `wait_cnt` clears on any cycle that is not a held WAIT.
- Errors:
  - `err` sets on the first error and `err_code` latches that error's code.
  - Later errors change neither. Only reset clears them.
  - When two errors arise in the same cycle, priority is overflow/underflow/timeout over range.

## Timing
- Reset (asynchronous assert, any time including mid-WAIT or mid-CALL): `next_state = 0`, stack empty, `stack_level = 0`, `wait_cnt = 0`, `err = 0`, `err_code = 00`.
- Release is synchronous to the next rising edge. The first state evaluated is 0.
- Latency is one cycle per microinstruction: `cw` for edge N determines `next_state` after edge N.
- `cw`, `decode_state`, `moc` and `cond` are sampled only at the rising edge. The decision is purely combinational from the current inputs.
- Stack updates are visible in `stack_level` the cycle after a CALL or RETURN.
- A CALL immediately followed by a RETURN returns to `inc` of the CALL state.
- Nested calls up to STACK_DEPTH are LIFO.
- A held WAIT lasts at most WAIT_LIMIT cycles. When `moc` arrives on the last allowed cycle, advance to `inc` with no error.

## Test plan
- Reset, then `cw = 40'h2100334c00` (sel = 001) with `decode_state = 20` → `next_state` 0 → 20 after one edge; `err = 0`.
- State 3 with WAIT, `csel = 001`, `moc` low for 5 cycles then high → `next_state` holds 3 for 5 cycles, `wait_cnt` counts 1..5, then moves to 4 and `wait_cnt = 0`.
- Hold WAIT with `moc = 0` for 1023 cycles → `next_state = 0`, `err = 1`, `err_code = 01`.
- At state 10, five nested CALLs to CR = 0x20 → levels 1..4, then the fifth CALL goes to state 0 with `err_code = 10`. Four RETURNs then give LIFO targets; a fifth RETURN goes to 0, `err` and `err_code` stay 10.
- BRANCH, `csel = 010`, `inv = 1`, `cond = 1`, CR = 0x40, at state 7 → `next_state = 8`. With `inv = 0` → `0x40`. With `NUM_STATES = 50` → 0, `err_code = 00`.
- Assert reset mid-WAIT with `stack_level = 2` → all outputs zero immediately, before any clock edge.

Source files
------------

// File: rtl/microsequencer.sv
// Next-state generator for the microprogrammed control unit: selects and registers the
// next microstore address, with a return stack, a bounded WAIT timeout and a sticky error.
module microsequencer #(
    parameter int NUM_STATES  = 256,
    parameter int STACK_DEPTH = 4,
    parameter int WAIT_LIMIT  = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [39:0] cw,
    input  logic [9:0]  decode_state,
    input  logic        moc,
    input  logic        cond,
    output logic [9:0]  next_state,
    output logic [2:0]  stack_level,
    output logic [9:0]  wait_cnt,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        SEL_RESTART = 3'b000,
        SEL_DECODE  = 3'b001,
        SEL_INC     = 3'b010,
        SEL_BRANCH  = 3'b011,
        SEL_WAIT    = 3'b100,
        SEL_BRDEC   = 3'b101,
        SEL_CALL    = 3'b110,
        SEL_RETURN  = 3'b111
    } sel_e;

    typedef enum logic [1:0] {
        ERR_RANGE     = 2'b00,
        ERR_TIMEOUT   = 2'b01,
        ERR_OVERFLOW  = 2'b10,
        ERR_UNDERFLOW = 2'b11
    } err_e;

    localparam int          IDX_W     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [2:0]  DEPTH_L   = 3'(STACK_DEPTH);
    localparam logic [9:0]  WAIT_LAST = 10'(WAIT_LIMIT - 1);
    localparam logic [10:0] NUM_L     = 11'(NUM_STATES);

    function automatic logic cond_select(input logic [2:0] csel_f, input logic moc_f,
                                         input logic cond_f);
        case (csel_f)
            3'b001:  return moc_f;
            3'b010:  return cond_f;
            3'b011:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    sel_e             sel;
    logic             c;
    logic [9:0]       inc;
    logic [9:0]       cr;
    logic [9:0]       target;
    logic             push;
    logic             pop;
    logic             hold_wait;
    logic             fault;
    err_e             fault_code;
    logic [9:0]       wait_next;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;
    logic [9:0]       stack_mem [STACK_DEPTH];
    logic             unused_cw;

    assign sel       = sel_e'(cw[39:37]);
    assign unused_cw = ^cw[36:12];
    assign push_idx  = IDX_W'(stack_level);
    assign pop_idx   = IDX_W'(stack_level - 3'd1);

    always_comb begin
        inc        = next_state + 10'd1;
        cr         = {2'b00, cw[7:0]};
        c          = cond_select(cw[10:8], moc, cond) ^ cw[11];
        target     = 10'd0;
        push       = 1'b0;
        pop        = 1'b0;
        hold_wait  = 1'b0;
        fault      = 1'b0;
        fault_code = ERR_RANGE;

        case (sel)
            SEL_RESTART: target = 10'd0;
            SEL_DECODE:  target = decode_state;
            SEL_INC:     target = inc;
            SEL_BRANCH:  target = c ? cr : inc;
            SEL_WAIT: begin
                if (c) begin
                    target = inc;
                end else if (wait_cnt == WAIT_LAST) begin
                    fault      = 1'b1;
                    fault_code = ERR_TIMEOUT;
                end else begin
                    target    = next_state;
                    hold_wait = 1'b1;
                end
            end
            SEL_BRDEC:   target = c ? cr : decode_state;
            SEL_CALL: begin
                if (stack_level == DEPTH_L) begin
                    fault      = 1'b1;
                    fault_code = ERR_OVERFLOW;
                end else begin
                    push   = 1'b1;
                    target = cr;
                end
            end
            SEL_RETURN: begin
                if (stack_level == 3'd0) begin
                    fault      = 1'b1;
                    fault_code = ERR_UNDERFLOW;
                end else begin
                    pop    = 1'b1;
                    target = stack_mem[pop_idx];
                end
            end
        endcase

        // Stack/timeout faults already force state 0, so they outrank the range check.
        if (!fault && ({1'b0, target} >= NUM_L)) begin
            target     = 10'd0;
            fault      = 1'b1;
            fault_code = ERR_RANGE;
        end

        wait_next = hold_wait ? (wait_cnt + 10'd1) : 10'd0;
    end

    // Registered state, stack depth, wait counter and sticky error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            next_state  <= 10'd0;
            stack_level <= 3'd0;
            wait_cnt    <= 10'd0;
            err         <= 1'b0;
            err_code    <= 2'b00;
        end else begin
            next_state <= target;
            wait_cnt   <= wait_next;
            if (push) begin
                stack_level <= stack_level + 3'd1;
            end else if (pop) begin
                stack_level <= stack_level - 3'd1;
            end
            if (fault && !err) begin
                err      <= 1'b1;
                err_code <= fault_code;
            end
        end
    end

    // Stack contents need no reset: entries above stack_level are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[push_idx] <= inc;
        end
    end

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for microsequencer: two instances (NUM_STATES 256 and 50) checked
// every cycle against a behavioural model, plus directed constant checks.
module tb_microsequencer;

    logic        clk;
    logic        reset;
    logic [39:0] cw;
    logic [9:0]  decode_state;
    logic        moc;
    logic        cond;

    logic [9:0] ns_a, ns_b, wc_a, wc_b;
    logic [2:0] lvl_a, lvl_b;
    logic       err_a, err_b;
    logic [1:0] code_a, code_b;

    microsequencer u_a (
        .clk(clk), .reset(reset), .cw(cw), .decode_state(decode_state), .moc(moc),
        .cond(cond), .next_state(ns_a), .stack_level(lvl_a), .wait_cnt(wc_a),
        .err(err_a), .err_code(code_a)
    );

    microsequencer #(.NUM_STATES(50)) u_b (
        .clk(clk), .reset(reset), .cw(cw), .decode_state(decode_state), .moc(moc),
        .cond(cond), .next_state(ns_b), .stack_level(lvl_b), .wait_cnt(wc_b),
        .err(err_b), .err_code(code_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [25:0] sb0[$];
    logic [25:0] sb1[$];

    // Behavioural model, one slot per instance
    int m_ns[2], m_lvl[2], m_wc[2], m_code[2];
    bit m_err[2];
    int m_stk[2][8];

    function automatic int lim(input int i);
        return (i == 0) ? 256 : 50;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ns[i] = 0; m_lvl[i] = 0; m_wc[i] = 0; m_err[i] = 0; m_code[i] = 0;
        end
    endfunction

    function automatic void model_step(input int i, input logic [39:0] w, input int ds,
                                       input bit mo, input bit co);
        int sel, csel, cr, nxt, tgt, fault;
        bit raw, c, held;
        sel   = int'(w[39:37]);
        csel  = int'(w[10:8]);
        cr    = int'(w[7:0]);
        raw   = (csel == 1) ? mo : (csel == 2) ? co : (csel == 3);
        c     = raw ^ w[11];
        nxt   = (m_ns[i] + 1) % 1024;
        tgt   = 0;
        fault = -1;
        held  = 0;
        case (sel)
            0: tgt = 0;
            1: tgt = ds;
            2: tgt = nxt;
            3: tgt = c ? cr : nxt;
            4: if (c) tgt = nxt;
               else if (m_wc[i] + 1 == 1023) begin tgt = 0; fault = 1; end
               else begin tgt = m_ns[i]; held = 1; end
            5: tgt = c ? cr : ds;
            6: if (m_lvl[i] == 4) begin tgt = 0; fault = 2; end
               else begin m_stk[i][m_lvl[i]] = nxt; m_lvl[i]++; tgt = cr; end
            default: if (m_lvl[i] == 0) begin tgt = 0; fault = 3; end
               else begin m_lvl[i]--; tgt = m_stk[i][m_lvl[i]]; end
        endcase
        if (fault < 0 && tgt >= lim(i)) begin tgt = 0; fault = 0; end
        m_wc[i] = held ? m_wc[i] + 1 : 0;
        if (fault >= 0 && !m_err[i]) begin m_err[i] = 1; m_code[i] = fault; end
        m_ns[i] = tgt;
    endfunction

    function automatic logic [25:0] snap(input int i);
        return {10'(m_ns[i]), 3'(m_lvl[i]), 10'(m_wc[i]), m_err[i], 2'(m_code[i])};
    endfunction

    function automatic logic [39:0] mk_cw(input logic [2:0] sel, input logic inv,
                                          input logic [2:0] csel, input logic [7:0] cr);
        return {sel, 25'd0, inv, csel, cr};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are presented every cycle; pop and compare after each edge
    always @(posedge clk) begin
        #1;
        if (sb0.size() > 0) chk("cycle_a", 32'({ns_a, lvl_a, wc_a, err_a, code_a}), 32'(sb0.pop_front()));
        if (sb1.size() > 0) chk("cycle_b", 32'({ns_b, lvl_b, wc_b, err_b, code_b}), 32'(sb1.pop_front()));
    end

    task automatic step(input logic [39:0] w, input logic [9:0] ds, input logic mo,
                        input logic co);
        @(negedge clk);
        reset = 1'b1;
        cw = w; decode_state = ds; moc = mo; cond = co;
        for (int i = 0; i < 2; i++) model_step(i, w, int'(ds), mo, co);
        sb0.push_back(snap(0));
        sb1.push_back(snap(1));
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a"}, 32'({ns_a, lvl_a, wc_a, err_a, code_a}), 32'd0);
        chk({tag, "_b"}, 32'({ns_b, lvl_b, wc_b, err_b, code_b}), 32'd0);
    endtask

    // Asserted mid-cycle, away from any edge; released by the next step()
    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
    endtask

    localparam logic [39:0] CW_DEC = 40'h2100334c00;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; cw = '0; decode_state = '0; moc = 1'b0; cond = 1'b0;
        model_reset();
        #1;
        check_zero("reset_state");

        // DECODE from state 0
        step(CW_DEC, 10'd20, 1'b0, 1'b0);
        settle();
        chk("decode_ns", 32'(ns_a), 32'd20);
        chk("decode_err", 32'(err_a), 32'd0);

        // WAIT at state 3 on moc, 5 held cycles then release
        step(mk_cw(3'b001, 1'b0, 3'b000, 8'd0), 10'd3, 1'b0, 1'b0);
        repeat (5) step(mk_cw(3'b100, 1'b0, 3'b001, 8'd0), 10'd0, 1'b0, 1'b0);
        settle();
        chk("wait_hold_ns", 32'(ns_a), 32'd3);
        chk("wait_hold_cnt", 32'(wc_a), 32'd5);
        step(mk_cw(3'b100, 1'b0, 3'b001, 8'd0), 10'd0, 1'b1, 1'b0);
        settle();
        chk("wait_rel_ns", 32'(ns_a), 32'd4);
        chk("wait_rel_cnt", 32'(wc_a), 32'd0);

        // WAIT timeout after 1023 held cycles
        do_reset();
        step(mk_cw(3'b001, 1'b0, 3'b000, 8'd0), 10'd3, 1'b0, 1'b0);
        repeat (1023) step(mk_cw(3'b100, 1'b0, 3'b001, 8'd0), 10'd0, 1'b0, 1'b0);
        settle();
        chk("timeout_ns", 32'(ns_a), 32'd0);
        chk("timeout_err", 32'(err_a), 32'd1);
        chk("timeout_code", 32'(code_a), 32'd1);

        // moc on the last allowed cycle advances without error
        do_reset();
        step(mk_cw(3'b001, 1'b0, 3'b000, 8'd0), 10'd3, 1'b0, 1'b0);
        repeat (1022) step(mk_cw(3'b100, 1'b0, 3'b001, 8'd0), 10'd0, 1'b0, 1'b0);
        step(mk_cw(3'b100, 1'b0, 3'b001, 8'd0), 10'd0, 1'b1, 1'b0);
        settle();
        chk("lastwait_ns", 32'(ns_a), 32'd4);
        chk("lastwait_err", 32'(err_a), 32'd0);

        // Nested calls, overflow, LIFO returns, underflow
        do_reset();
        step(mk_cw(3'b001, 1'b0, 3'b000, 8'd0), 10'd10, 1'b0, 1'b0);
        repeat (4) step(mk_cw(3'b110, 1'b0, 3'b000, 8'h20), 10'd0, 1'b0, 1'b0);
        settle();
        chk("call_level", 32'(lvl_a), 32'd4);
        step(mk_cw(3'b110, 1'b0, 3'b000, 8'h20), 10'd0, 1'b0, 1'b0);
        settle();
        chk("overflow_ns", 32'(ns_a), 32'd0);
        chk("overflow_code", 32'({err_a, code_a}), 32'h6);
        repeat (4) step(mk_cw(3'b111, 1'b0, 3'b000, 8'd0), 10'd0, 1'b0, 1'b0);
        settle();
        chk("ret_last_ns", 32'(ns_a), 32'd11);
        step(mk_cw(3'b111, 1'b0, 3'b000, 8'd0), 10'd0, 1'b0, 1'b0);
        settle();
        chk("underflow_ns", 32'(ns_a), 32'd0);
        chk("underflow_sticky", 32'({err_a, code_a}), 32'h6);

        // BRANCH with inverted / plain condition, and range fault in the small instance
        do_reset();
        step(mk_cw(3'b001, 1'b0, 3'b000, 8'd0), 10'd7, 1'b0, 1'b0);
        step(mk_cw(3'b011, 1'b1, 3'b010, 8'h40), 10'd0, 1'b0, 1'b1);
        settle();
        chk("branch_inv_ns", 32'(ns_a), 32'd8);
        step(mk_cw(3'b001, 1'b0, 3'b000, 8'd0), 10'd7, 1'b0, 1'b0);
        step(mk_cw(3'b011, 1'b0, 3'b010, 8'h40), 10'd0, 1'b0, 1'b1);
        settle();
        chk("branch_ns", 32'(ns_a), 32'h40);
        chk("range_ns_b", 32'(ns_b), 32'd0);
        chk("range_err_b", 32'({err_b, code_b}), 32'h4);

        // Reset mid-WAIT with two stack entries
        do_reset();
        step(mk_cw(3'b001, 1'b0, 3'b000, 8'd0), 10'd10, 1'b0, 1'b0);
        repeat (2) step(mk_cw(3'b110, 1'b0, 3'b000, 8'h20), 10'd0, 1'b0, 1'b0);
        repeat (3) step(mk_cw(3'b100, 1'b0, 3'b001, 8'd0), 10'd0, 1'b0, 1'b0);
        settle();
        chk("pre_reset_level", 32'(lvl_a), 32'd2);
        do_reset();

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            if (n % 160 == 159) do_reset();
            step(mk_cw(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)), 8'($urandom)),
                 10'($urandom_range(0, 299)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        settle();
        chk("sb_drained", 32'(sb0.size() + sb1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
